mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data-port grants while the fetch port is waiting.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port if_req_i, input, 1, instruction-fetch request; held high until if_ack_o.
REQ-005 SHALL have port if_addr_i, input, 32, fetch byte address; stable while if_req_i is high.
REQ-006 SHALL have port if_ack_o, output, 1, one-cycle fetch completion pulse.
REQ-007 SHALL have port if_rdata_o, output, 32, fetch data; valid only while if_ack_o is high.
REQ-008 SHALL have port dm_req_i, input, 1, data-memory request; held high until dm_ack_o.
REQ-009 SHALL have port dm_we_i, input, 1, data request is a write (1) or a read (0).
REQ-010 SHALL have port dm_addr_i, input, 32, data byte address.
REQ-011 SHALL have port dm_wdata_i, input, 32, data write value.
REQ-012 SHALL have port dm_ack_o, output, 1, one-cycle data completion pulse.
REQ-013 SHALL have port dm_rdata_o, output, 32, read data; valid only while dm_ack_o is high.
REQ-014 SHALL have port if_stall_o, output, 1, stall to the PC/IFID logic.
REQ-015 SHALL have port dm_stall_o, output, 1, stall to the whole pipeline.
REQ-016 SHALL have port mem_enable_o, output, 1, one-cycle start strobe to the backing memory.
REQ-017 SHALL have port mem_write_o, output, 1, write qualifier for the backing memory.
REQ-018 SHALL have port mem_addr_o, output, 32, address to the backing memory.
REQ-019 SHALL have port mem_wdata_o, output, 32, write data to the backing memory.
REQ-020 SHALL have port mem_ack_i, input, 1, one-cycle memory completion pulse; latency is 1 or more cycles after mem_enable_o.
REQ-021 SHALL have port mem_rdata_i, input, 32, read data; valid while mem_ack_i is high.

Function
REQ-022 SHALL implement an FSM with states IDLE, IF_BUSY and DM_BUSY.
REQ-023 In IDLE, a data request SHALL be granted over a fetch request, unless starve_cnt == STARVE_LIMIT and if_req_i is high; in that case the fetch request is granted.
REQ-024 A grant SHALL move the FSM to IF_BUSY or DM_BUSY at the next edge.
REQ-025 At that same edge the block SHALL register mem_addr_o, mem_wdata_o and mem_write_o from the granted port, with mem_write_o = 0 for a fetch.
REQ-026 mem_enable_o SHALL be high for exactly the first cycle in a BUSY state.
REQ-027 mem_addr_o, mem_wdata_o and mem_write_o SHALL stay stable until the FSM returns to IDLE.
REQ-028 In a BUSY state, mem_ack_i high SHALL combinationally drive the owning port's ack and copy mem_rdata_i to its rdata output; the FSM returns to IDLE at the next edge.
REQ-029 Minimum request-to-ack latency SHALL be 2 cycles: grant edge, then enable cycle, then ack in the following cycle when memory latency is 1.
REQ-030 mem_ack_i SHALL be ignored in IDLE and in the enable cycle of a BUSY state.
REQ-031 if_stall_o SHALL equal if_req_i & ~if_ack_o.
REQ-032 dm_stall_o SHALL equal dm_req_i & ~dm_ack_o.
REQ-033 starve_cnt SHALL be 3 bits and saturating:
- increments on each data grant while if_req_i is high;
- clears on each fetch grant;
- clears in any IDLE cycle with if_req_i low.
REQ-034 A requester SHALL drop its request in the cycle after its ack; a request still high in IDLE is treated as a new request.
REQ-035 Both requests arriving in the same IDLE cycle SHALL follow REQ-023; the loser is served in the next IDLE cycle, with no lost request.
REQ-036 An address bit 0/1 misalignment SHALL be passed through unmodified; the memory model owns alignment.

Reset
REQ-037 On rst_i high, asynchronously:
- state = IDLE and starve_cnt = 0;
- mem_enable_o, mem_write_o = 0;
- mem_addr_o, mem_wdata_o = 0.
REQ-038 While rst_i is high, if_ack_o and dm_ack_o SHALL be 0 and rdata outputs SHALL be 0.
REQ-039 Reset mid-transaction SHALL abandon the access, and no ack SHALL be generated for it.
REQ-040 The first cycle after reset release SHALL behave as IDLE.

Verification
REQ-041 Fetch alone: if_req_i=1, if_addr_i=0x0000_0010, memory latency 3 -> mem_enable_o one cycle with mem_addr_o=0x10 and mem_write_o=0; if_ack_o for one cycle 4 cycles after grant, if_rdata_o equal to the memory word; if_stall_o=1 until then.
REQ-042 Simultaneous requests: if_req_i=1, dm_req_i=1, dm_we_i=1, dm_addr_i=0x80, dm_wdata_i=0xDEAD_BEEF -> data is served first with the memory write seen at 0x80; the fetch is granted in the IDLE cycle after dm_ack_o.
REQ-043 Starvation: if_req_i held high and dm_req_i re-asserted every IDLE cycle, STARVE_LIMIT=4 -> exactly 4 data grants, then 1 fetch grant, then starve_cnt=0.
REQ-044 Reset mid-access: rst_i pulsed 1 cycle during DM_BUSY, then a late mem_ack_i -> no dm_ack_o, state IDLE, all memory-side outputs 0.
REQ-045 Spurious ack: mem_ack_i=1 in IDLE with both requests low -> no ack outputs and no state change.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one backing memory between instruction fetch and data access.
// Data wins by default; a saturating starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_ack_o,
  output logic [31:0] dm_rdata_o,
  output logic        if_stall_o,
  output logic        dm_stall_o,
  output logic        mem_enable_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned DW    = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_starve_nxt;
  logic             r_mem_enable;
  logic             r_mem_write;
  logic [DW-1:0]    r_mem_addr;
  logic [DW-1:0]    r_mem_wdata;
  logic             w_starved;
  logic             w_grant_if;
  logic             w_grant_dm;
  logic             w_mem_done;

  // Completion is only honoured after the enable cycle of a busy state.
  assign w_mem_done = (r_state != IDLE) & ~r_mem_enable & mem_ack_i & ~rst_i;
  assign w_starved  = if_req_i & (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_if   = 1'b0;
    w_grant_dm   = 1'b0;
    w_starve_nxt = r_starve_cnt;
    case (r_state)
      IDLE: begin
        if (dm_req_i && !w_starved) begin
          w_grant_dm  = 1'b1;
          w_state_nxt = DM_BUSY;
        end else if (if_req_i) begin
          w_grant_if  = 1'b1;
          w_state_nxt = IF_BUSY;
        end
        if (w_grant_if || !if_req_i) begin
          w_starve_nxt = '0;
        end else if (w_grant_dm && (r_starve_cnt != '1)) begin
          w_starve_nxt = r_starve_cnt + CNT_W'(1);
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (w_mem_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Memory-side command is captured at the grant edge and held until return to IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_mem_enable <= w_grant_if | w_grant_dm;
      if (w_grant_dm) begin
        r_mem_write <= dm_we_i;
        r_mem_addr  <= dm_addr_i;
        r_mem_wdata <= dm_wdata_i;
      end else if (w_grant_if) begin
        r_mem_write <= 1'b0;
        r_mem_addr  <= if_addr_i;
        r_mem_wdata <= '0;
      end
    end
  end

  assign if_ack_o     = w_mem_done & (r_state == IF_BUSY);
  assign dm_ack_o     = w_mem_done & (r_state == DM_BUSY);
  assign if_rdata_o   = if_ack_o ? mem_rdata_i : '0;
  assign dm_rdata_o   = dm_ack_o ? mem_rdata_i : '0;
  assign if_stall_o   = if_req_i & ~if_ack_o;
  assign dm_stall_o   = dm_req_i & ~dm_ack_o;
  assign mem_enable_o = r_mem_enable;
  assign mem_write_o  = r_mem_write;
  assign mem_addr_o   = r_mem_addr;
  assign mem_wdata_o  = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expectations, a monitor pops them on acks/enables.
module tb_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        if_stall;
  logic        dm_stall;
  logic        mem_enable;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata = 32'hFFFF_FFFF;

  logic        model_ack = 1'b0;
  logic        spur_ack = 1'b0;
  int          lat = 1;
  int          mcnt = 0;
  logic        m_we = 1'b0;
  logic [31:0] m_addr = '0;

  int n_checks = 0;
  int n_pass = 0;

  mem_t        exp_mem[$];
  logic [31:0] exp_if[$];
  logic [31:0] exp_dm[$];

  assign mem_ack = model_ack | spur_ack;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata),
    .if_stall_o(if_stall), .dm_stall_o(dm_stall),
    .mem_enable_o(mem_enable), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Backing memory: ack arrives lat cycles after the enable cycle; writes return zero.
  always @(posedge clk) begin
    #1;
    model_ack = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        model_ack = 1'b1;
        mem_rdata = m_we ? 32'h0 : mem_word(m_addr);
      end
    end
    if (mem_enable) begin
      mcnt   = lat;
      m_we   = mem_write;
      m_addr = mem_addr;
    end
  end

  mem_t e;
  always @(negedge clk) begin
    if (!rst) begin
      chk("one_ack_at_a_time", 32'(if_ack & dm_ack), 32'h0);
      if (if_ack) begin
        if (exp_if.size() == 0) chk("if_ack_spurious", 32'(if_ack), 32'h0);
        else chk("if_rdata", if_rdata, exp_if.pop_front());
      end
      if (dm_ack) begin
        if (exp_dm.size() == 0) chk("dm_ack_spurious", 32'(dm_ack), 32'h0);
        else chk("dm_rdata", dm_rdata, exp_dm.pop_front());
      end
      if (mem_enable) begin
        if (exp_mem.size() == 0) chk("mem_enable_spurious", 32'(mem_enable), 32'h0);
        else begin
          e = exp_mem.pop_front();
          chk("mem_write", 32'(mem_write), 32'(e.we));
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_wdata", mem_wdata, e.wdata);
        end
      end
    end
  end

  // Waits for the port's ack; returns cycles counted from the current cycle (1 = this cycle).
  task automatic wait_ack(input bit is_if, input int max, output int n);
    n = 0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      n++;
      if (is_if ? if_ack : dm_ack) begin
        chk(is_if ? "if_stall_at_ack" : "dm_stall_at_ack", 32'(is_if ? if_stall : dm_stall), 32'h0);
        return;
      end
      chk(is_if ? "if_stall_wait" : "dm_stall_wait", 32'(is_if ? if_stall : dm_stall), 32'h1);
    end
    n_checks++;
    $display("FAIL ack_timeout: got no ack expected ack within %0d cycles", max);
    n = -1;
  endtask

  task automatic wait_any(input int max, output int kind);
    kind = 2;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (if_ack) begin kind = 1; return; end
      if (dm_ack) begin kind = 0; return; end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int n;
    int kind;
    logic [31:0] da;

    // Reset: outputs quiet even with a memory ack present.
    spur_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_if_ack", 32'(if_ack), 32'h0);
    chk("rst_dm_ack", 32'(dm_ack), 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    chk("rst_mem_enable", 32'(mem_enable), 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    spur_ack = 1'b0;

    // Fetch alone, memory latency 3, first cycle after reset release.
    @(posedge clk); #1;
    rst = 1'b0;
    lat = 3;
    if_req = 1'b1; if_addr = 32'h0000_0010;
    exp_mem.push_back('{1'b0, 32'h10, 32'h0});
    exp_if.push_back(mem_word(32'h10));
    wait_ack(1'b1, 20, n);
    chk("fetch_latency", 32'(n), 32'd5);
    @(posedge clk); #1;
    if_req = 1'b0;

    // Simultaneous requests: data write first, fetch in the following IDLE cycle.
    @(posedge clk); #1;
    lat = 1;
    if_req = 1'b1; if_addr = 32'h44;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hDEAD_BEEF;
    exp_mem.push_back('{1'b1, 32'h80, 32'hDEAD_BEEF});
    exp_mem.push_back('{1'b0, 32'h44, 32'h0});
    exp_dm.push_back(32'h0);
    exp_if.push_back(mem_word(32'h44));
    wait_ack(1'b0, 20, n);
    chk("dm_min_latency", 32'(n), 32'd3);
    @(posedge clk); #1;
    dm_req = 1'b0; dm_we = 1'b0; dm_wdata = 32'h0;
    wait_ack(1'b1, 20, n);
    chk("fetch_after_dm", 32'(n), 32'd3);
    @(posedge clk); #1;
    if_req = 1'b0;

    // Starvation: both held high; expect D D D D F twice.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b1; dm_addr = 32'h200;
    da = 32'h200;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        exp_mem.push_back('{1'b0, da, 32'h0});
        exp_dm.push_back(mem_word(da));
        da = da + 32'd4;
      end
      exp_mem.push_back('{1'b0, 32'h100, 32'h0});
      exp_if.push_back(mem_word(32'h100));
    end
    for (int t = 0; t < 10; t++) begin
      wait_any(20, kind);
      chk($sformatf("starve_order_%0d", t), 32'(kind), ((t % 5) == 4) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      if (kind == 0) dm_addr = dm_addr + 32'd4;
    end
    if_req = 1'b0; dm_req = 1'b0;

    // Reset pulse during DM_BUSY, then a late memory ack.
    @(posedge clk); #1;
    lat = 5;
    dm_req = 1'b1; dm_addr = 32'h300;
    exp_mem.push_back('{1'b0, 32'h300, 32'h0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; dm_req = 1'b0;
    @(negedge clk);
    chk("midrst_dm_ack", 32'(dm_ack), 32'h0);
    chk("midrst_mem_enable", 32'(mem_enable), 32'h0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("late_ack_dm_ack", 32'(dm_ack), 32'h0);
      chk("late_ack_mem_out", {mem_addr[29:0], mem_write, mem_enable} | mem_wdata, 32'h0);
    end

    // Spurious ack in IDLE: no ack, no grant.
    @(posedge clk); #1;
    spur_ack = 1'b1;
    @(negedge clk);
    chk("spur_idle_if_ack", 32'(if_ack), 32'h0);
    chk("spur_idle_dm_ack", 32'(dm_ack), 32'h0);
    @(posedge clk); #1;
    spur_ack = 1'b0;
    @(negedge clk);
    chk("spur_idle_no_enable", 32'(mem_enable), 32'h0);

    // Ack during the enable cycle is ignored; misaligned address passes through.
    @(posedge clk); #1;
    lat = 2;
    if_req = 1'b1; if_addr = 32'h0000_0013;
    exp_mem.push_back('{1'b0, 32'h13, 32'h0});
    exp_if.push_back(mem_word(32'h13));
    @(posedge clk); #1;
    spur_ack = 1'b1;
    @(negedge clk);
    chk("spur_enable_if_ack", 32'(if_ack), 32'h0);
    @(posedge clk); #1;
    spur_ack = 1'b0;
    wait_ack(1'b1, 20, n);
    chk("fetch_after_spur_latency", 32'(n), 32'd2);
    @(posedge clk); #1;
    if_req = 1'b0;

    repeat (3) @(negedge clk);
    chk("exp_mem_drained", 32'(exp_mem.size()), 32'h0);
    chk("exp_if_drained", 32'(exp_if.size()), 32'h0);
    chk("exp_dm_drained", 32'(exp_dm.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
